// File: rtl/sreg_seq_if.sv
// Job, row-stream and command-port bundle between a job source/controller (master) and sreg_seq (slave).
// Flow control: row_valid/row_ready for row words, cmd_valid/cmd_ready for commands.
interface sreg_seq_if;
  logic        start;
  logic        mode;
  logic [5:0]  row_cnt;
  logic [41:0] cfg_word;

  logic        row_valid;
  logic        row_ready;
  logic [41:0] row_data;

  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [41:0] cmd_data;
  logic        cmd_ready;

  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  rows_done;

  modport master (
    output start, mode, row_cnt, cfg_word, row_valid, row_data, cmd_ready,
    input  row_ready, cmd_valid, cmd, cmd_data, busy, done, err, rows_done
  );

  modport slave (
    input  start, mode, row_cnt, cfg_word, row_valid, row_data, cmd_ready,
    output row_ready, cmd_valid, cmd, cmd_data, busy, done, err, rows_done
  );
endinterface

// File: rtl/sreg_seq.sv
// Row/command sequencer for a pixel shift-register controller: one command in flight, all outputs registered.
// Stalls in FETCH while row_valid is low and in ISSUE/FINAL/WAIT_DONE while cmd_ready is low.
module sreg_seq (
  input  logic      clk,
  input  logic      rst_n,
  sreg_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    ACKED,
    WAIT_DONE,
    FINAL,
    DONE
  } state_t;

  localparam logic [2:0] OP_PIX_WRITE    = 3'b000;
  localparam logic [2:0] OP_PIX_READ     = 3'b001;
  localparam logic [2:0] OP_PIX_READ_END = 3'b010;
  localparam logic [2:0] OP_WRITE_FULL   = 3'b110;

  state_t      state_q;
  logic        mode_q;
  logic        final_q;
  logic [5:0]  row_cnt_q;
  logic [41:0] cfg_q;
  logic [5:0]  rows_done_q;
  logic [5:0]  rows_done_d;
  logic        cmd_valid_q;
  logic [2:0]  cmd_q;
  logic [41:0] cmd_data_q;
  logic        row_ready_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  // row_cnt is at most 63 and rows_done stays below it, so this never wraps
  assign rows_done_d = rows_done_q + 6'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      final_q     <= 1'b0;
      row_cnt_q   <= '0;
      cfg_q       <= '0;
      rows_done_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= OP_PIX_WRITE;
      cmd_data_q  <= '0;
      row_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.row_cnt == 6'd0) begin
              err_q <= 1'b1;
            end else begin
              mode_q      <= bus.mode;
              row_cnt_q   <= bus.row_cnt;
              cfg_q       <= bus.cfg_word;
              rows_done_q <= '0;
              final_q     <= 1'b0;
              busy_q      <= 1'b1;
              if (bus.mode) begin
                state_q     <= ISSUE;
                cmd_valid_q <= 1'b1;
                cmd_q       <= OP_PIX_READ;
                cmd_data_q  <= '0;
              end else begin
                state_q     <= FETCH;
                row_ready_q <= 1'b1;
              end
            end
          end
        end

        FETCH: begin
          // the fetched row word goes straight into the command buffer
          if (bus.row_valid) begin
            row_ready_q <= 1'b0;
            cmd_valid_q <= 1'b1;
            cmd_q       <= OP_PIX_WRITE;
            cmd_data_q  <= bus.row_data;
            state_q     <= ISSUE;
          end
        end

        ISSUE, FINAL: begin
          if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ACKED;
          end
        end

        ACKED: begin
          state_q <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (bus.cmd_ready) begin
            if (final_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              rows_done_q <= rows_done_d;
              if (rows_done_d < row_cnt_q) begin
                if (mode_q) begin
                  state_q     <= ISSUE;
                  cmd_valid_q <= 1'b1;
                  cmd_q       <= OP_PIX_READ;
                  cmd_data_q  <= '0;
                end else begin
                  state_q     <= FETCH;
                  row_ready_q <= 1'b1;
                end
              end else begin
                state_q     <= FINAL;
                final_q     <= 1'b1;
                cmd_valid_q <= 1'b1;
                cmd_q       <= mode_q ? OP_PIX_READ_END : OP_WRITE_FULL;
                cmd_data_q  <= mode_q ? 42'd0 : cfg_q;
              end
            end
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.row_ready = row_ready_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_data  = cmd_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rows_done = rows_done_q;

endmodule
